// File: rtl/alarm_pkg.sv
// Shared alarm-clock definitions: adjust field codes, set-mode state encoding
// and helpers for sizing counters and mapping states to field selects.
package alarm_pkg;

   localparam logic [1:0] ADJ_SEC  = 2'd0;
   localparam logic [1:0] ADJ_MIN  = 2'd1;
   localparam logic [1:0] ADJ_HOUR = 2'd2;
   localparam logic [1:0] ADJ_NONE = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2,
      ST_SET_SEC  = 2'd3
   } state_t;

   // Bits needed for a counter that runs 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [1:0] adj_of(input state_t s);
      case (s)
         ST_SET_HOUR: return ADJ_HOUR;
         ST_SET_MIN:  return ADJ_MIN;
         ST_SET_SEC:  return ADJ_SEC;
         default:     return ADJ_NONE;
      endcase
   endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Key inputs and counter-chain controls between the debouncers, the set
// controller and the hour/minute/second counters.
interface time_set_ctrl_if;
   logic       sw17;
   logic       key_mode;
   logic       key_up;
   logic       key_dn;
   logic [1:0] adjust;
   logic       key_inc;
   logic       key_dec;
   logic       en;
   logic       blink;

   modport master (
      output sw17, key_mode, key_up, key_dn,
      input  adjust, key_inc, key_dec, en, blink
   );

   modport slave (
      input  sw17, key_mode, key_up, key_dn,
      output adjust, key_inc, key_dec, en, blink
   );
endinterface

// File: rtl/key_repeat.sv
// Turns one debounced key level into a single-cycle press pulse followed by
// auto-repeat pulses while the key stays held.
module key_repeat
   import alarm_pkg::*;
#(
   parameter int REPEAT_DLY = 25_000_000,
   parameter int REPEAT_PER = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   input  logic enable,
   input  logic inhibit,
   output logic rise,
   output logic pulse
);

   localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CNT_W   = cnt_width(RPT_MAX);

   logic             prev_reg;
   logic             active_reg, active_next;
   logic             first_reg, first_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             pulse_reg, pulse_next;

   assign rise  = key & ~prev_reg;
   assign pulse = pulse_reg;

   // A repeat only runs after a press pulse; losing the key, the enable or
   // seeing both keys down drops it, so resuming always needs a fresh edge.
   always_comb begin
      active_next = active_reg;
      first_next  = first_reg;
      cnt_next    = cnt_reg;
      pulse_next  = 1'b0;
      if (!enable || inhibit || !key) begin
         active_next = 1'b0;
         first_next  = 1'b0;
         cnt_next    = '0;
      end else if (rise) begin
         pulse_next  = 1'b1;
         active_next = 1'b1;
         first_next  = 1'b1;
         cnt_next    = '0;
      end else if (active_reg) begin
         if ((first_reg && cnt_reg == CNT_W'(REPEAT_DLY - 1)) ||
             (!first_reg && cnt_reg == CNT_W'(REPEAT_PER - 1))) begin
            pulse_next = 1'b1;
            first_next = 1'b0;
            cnt_next   = '0;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_reg   <= 1'b0;
         active_reg <= 1'b0;
         first_reg  <= 1'b0;
         cnt_reg    <= '0;
         pulse_reg  <= 1'b0;
      end else begin
         prev_reg   <= key;
         active_reg <= active_next;
         first_reg  <= first_next;
         cnt_reg    <= cnt_next;
         pulse_reg  <= pulse_next;
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Set-mode sequencer for the alarm clock counter chain: field select FSM,
// idle timeout, 1 Hz enable prescaler, blink timer and up/down key pulses.
module time_set_ctrl
   import alarm_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int REPEAT_DLY = 25_000_000,
   parameter int REPEAT_PER = 5_000_000,
   parameter int TIMEOUT    = 500_000_000
) (
   input  logic           clk,
   input  logic           rst,
   time_set_ctrl_if.slave bus
);

   localparam int HALF_DIV = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
   localparam int TICK_W   = cnt_width(TICK_DIV);
   localparam int BLK_W    = cnt_width(HALF_DIV);
   localparam int IDLE_W   = cnt_width(TIMEOUT);

   state_t              state_reg, state_next;
   logic                mode_prev_reg;
   logic                mode_rise;
   logic [1:0]          key_vec, rise_vec, pulse_vec;
   logic                in_set, timeout_hit, leave_set, rep_enable, both_held;
   logic [IDLE_W-1:0]   idle_reg, idle_next;
   logic [TICK_W-1:0]   presc_reg, presc_next;
   logic [BLK_W-1:0]    blk_cnt_reg, blk_cnt_next;
   logic                en_reg, en_next;
   logic                blink_reg, blink_next;
   logic [1:0]          adjust_reg, adjust_next;

   assign mode_rise   = bus.key_mode & ~mode_prev_reg;
   assign in_set      = (state_reg != ST_RUN);
   assign timeout_hit = in_set && (idle_reg == IDLE_W'(TIMEOUT - 1));
   assign leave_set   = !bus.sw17 || timeout_hit;
   // A mode edge wins over a simultaneous up/down edge.
   assign rep_enable  = in_set & bus.sw17 & ~mode_rise & ~timeout_hit;
   assign both_held   = bus.key_up & bus.key_dn;
   assign key_vec     = {bus.key_dn, bus.key_up};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_key
         key_repeat #(
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
         ) u_rep (
            .clk     (clk),
            .rst     (rst),
            .key     (key_vec[gi]),
            .enable  (rep_enable),
            .inhibit (both_held),
            .rise    (rise_vec[gi]),
            .pulse   (pulse_vec[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN: begin
            if (mode_rise && bus.sw17) state_next = ST_SET_HOUR;
         end
         ST_SET_HOUR: begin
            if (leave_set)      state_next = ST_RUN;
            else if (mode_rise) state_next = ST_SET_MIN;
         end
         ST_SET_MIN: begin
            if (leave_set)      state_next = ST_RUN;
            else if (mode_rise) state_next = ST_SET_SEC;
         end
         default: begin
            if (leave_set || mode_rise) state_next = ST_RUN;
         end
      endcase
   end

   always_comb begin
      adjust_next  = adj_of(state_next);
      idle_next    = idle_reg + 1'b1;
      presc_next   = '0;
      en_next      = 1'b0;
      blk_cnt_next = '0;
      blink_next   = 1'b0;
      if (state_next == ST_RUN || state_next != state_reg || mode_rise || (|rise_vec)) begin
         idle_next = '0;
      end
      // Only a full cycle of RUN counts, so no tick escapes on the entry edge
      // and the first tick after exit is a full period away.
      if (state_reg == ST_RUN && state_next == ST_RUN) begin
         if (presc_reg == TICK_W'(TICK_DIV - 1)) begin
            en_next = 1'b1;
         end else begin
            presc_next = presc_reg + 1'b1;
         end
      end
      if (state_next != ST_RUN) begin
         blink_next = blink_reg;
         if (blk_cnt_reg == BLK_W'(HALF_DIV - 1)) begin
            blink_next = ~blink_reg;
         end else begin
            blk_cnt_next = blk_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_prev_reg <= 1'b0;
         idle_reg      <= '0;
         presc_reg     <= '0;
         blk_cnt_reg   <= '0;
         en_reg        <= 1'b0;
         blink_reg     <= 1'b0;
         adjust_reg    <= ADJ_NONE;
      end else begin
         mode_prev_reg <= bus.key_mode;
         idle_reg      <= idle_next;
         presc_reg     <= presc_next;
         blk_cnt_reg   <= blk_cnt_next;
         en_reg        <= en_next;
         blink_reg     <= blink_next;
         adjust_reg    <= adjust_next;
      end
   end

   assign bus.adjust  = adjust_reg;
   assign bus.key_inc = pulse_vec[0];
   assign bus.key_dec = pulse_vec[1];
   assign bus.en      = en_reg;
   assign bus.blink   = blink_reg;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Controller that sequences the hour/minute/second counter chain of the alarm clock. It generates the 1 Hz count enable and the `adjust` field select. It also turns the debounced up/down buttons into single-cycle increment/decrement pulses, with auto-repeat while a button is held. It sits between the key debouncers and the counter modules: each counter compares `adjust` against its own fixed `mode` code and accepts `key2`/`key3` pulses only when selected and `sw17` is high.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000 — clock cycles per count-enable tick (1 Hz at 50 MHz).
- `REPEAT_DLY`, 25_000_000 — cycles from the initial press pulse to the first auto-repeat pulse.
- `REPEAT_PER`, 5_000_000 — cycles between subsequent auto-repeat pulses.
- `TIMEOUT`, 500_000_000 — idle cycles in a set state before returning to RUN.

Ports:
- `clk`  in  1 — single system clock.
- `rst`  in  1 — synchronous, active-high reset.
- `sw17`  in  1 — set-mode enable switch (level).
- `key_mode`  in  1 — debounced mode button, active-high level.
- `key_up`  in  1 — debounced up button, active-high level.
- `key_dn`  in  1 — debounced down button, active-high level.
- `adjust`  out  2 — selected field: 0 = sec, 1 = min, 2 = hour, 3 = none.
- `key_inc`  out  1 — one-cycle increment pulse to the counters (`key2`).
- `key_dec`  out  1 — one-cycle decrement pulse to the counters (`key3`).
- `en`  out  1 — one-cycle count-enable pulse to the seconds counter.
- `blink`  out  1 — display blank for the selected field.

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC. `adjust` is 3 in RUN, 2 in SET_HOUR, 1 in SET_MIN and 0 in SET_SEC.
- Transitions:
  - RUN → SET_HOUR on a rising edge of `key_mode` while `sw17`=1.
  - SET_HOUR → SET_MIN → SET_SEC → RUN, each on a rising edge of `key_mode`.
  - Any set state → RUN when `sw17`=0, with priority over everything else.
  - Any set state → RUN when the idle counter reaches `TIMEOUT`-1.
- Idle counter: cleared on entering a set state and on any `key_up`, `key_dn` or `key_mode` rising edge; held at 0 in RUN.
- Up/down handling:
  - Active only in set states. In RUN, `key_inc` and `key_dec` stay 0.
  - Rising edge of a key → one pulse on its output.
  - While the key is held: the next pulse comes `REPEAT_DLY` cycles after the initial pulse, then one every `REPEAT_PER` cycles.
  - Release stops repeating immediately.
- Both up and down high: no pulses, and both repeat counters are held at 0. Releasing one does not generate a new initial pulse for the other, because an initial pulse needs a rising edge.
- `key_inc` and `key_dec` are never high in the same cycle.
- Prescaler counts 0..`TICK_DIV`-1 in RUN; `en` pulses when it wraps. In set states the prescaler is held at 0 and `en`=0, so the first tick after exit comes `TICK_DIV` cycles later.
- `blink` toggles each time the prescaler-equivalent half period (`TICK_DIV`/2 cycles) elapses in set states; it is 0 in RUN. A separate counter keeps running in set states to drive it.

## Timing
- Reset values: state RUN, `adjust`=3, `key_inc`=`key_dec`=`en`=`blink`=0, all counters 0, edge-detect registers 0.
- All outputs are registered.
- Key inputs are sampled into a previous-value register; a rising edge is input=1 and previous=0.
- Initial pulse asserts on the clock edge after the edge sample, i.e. latency is 1 cycle.
- State changes take effect on the cycle after the `key_mode` edge is detected. `adjust` updates in that same cycle.
- A `key_mode` edge and an up/down edge in the same cycle: the state advances and the up/down pulse is suppressed.
- Reset mid-operation (repeat, set state, timeout): everything returns to reset values on the next edge. No pulse is emitted in the cycle after reset.
- Counter widths use `$clog2` of the parameter. `TIMEOUT` needs ≥ 29 bits at the default value.

## Structure
- Shared package `alarm_pkg`:
  - adjust codes `ADJ_SEC`=0, `ADJ_MIN`=1, `ADJ_HOUR`=2, `ADJ_NONE`=3.
  - state encoding for the four states.
- Sub-module `key_repeat`: edge detect, hold counter and pulse output. It has an `enable` input and an `inhibit` input for the both-pressed case. It is instantiated twice, once for up and once for down.
- The FSM, idle counter, prescaler and blink stay in the top module.

## Test plan
Bench parameters for all scenarios: `TICK_DIV`=10, `REPEAT_DLY`=20, `REPEAT_PER`=5, `TIMEOUT`=100.
1. Reset, `sw17`=0, run 35 cycles → `en` pulses at cycles 10, 20, 30; `adjust`=3; `blink`=0.
2. `sw17`=1, then four `key_mode` presses → `adjust` goes 2, 1, 0, 3. `en` is silent while `adjust`≠3, and the first `en` comes 10 cycles after returning to 3.
3. In SET_HOUR, hold `key_up` 50 cycles → `key_inc` at press+1, +21, +26, +31, … +46 (7 pulses total). `key_dec`=0 throughout.
4. In SET_MIN, press `key_up` and `key_dn` together for 40 cycles → no pulses. Release `key_dn` → still no `key_inc` until `key_up` is re-pressed.
5. In SET_SEC, no keys for 100 cycles → `adjust` returns to 3 at cycle 100. A repeat of this run with a `key_dn` press at cycle 60 extends the return to cycle 160.
6. In SET_HOUR while holding `key_up`, drop `sw17` → RUN next cycle, `adjust`=3, pulses stop. Assert `rst` mid-repeat → all outputs 0 and `adjust`=3 on the next cycle.
